// File: rtl/modbus_rtu_rsp_parser_if.sv
// Byte input and register write bus for the Modbus RTU response parser.
// The slave side is the parser; the master side feeds bytes and watches outputs.
interface modbus_rtu_rsp_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  adr;
  logic [7:0]  n_data;
  logic [15:0] data_in;
  logic        data_strb;
  logic        crc_validate;
  logic        frame_ok;
  logic        frame_err;
  logic [2:0]  err_code;

  modport slave (
    input  rx_data, rx_valid,
    output adr, n_data, data_in, data_strb,
    output crc_validate, frame_ok, frame_err, err_code
  );

  modport master (
    output rx_data, rx_valid,
    input  adr, n_data, data_in, data_strb,
    input  crc_validate, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/modbus_rtu_rsp_parser.sv
// Modbus RTU read-registers response parser (func 0x03/0x04).
// Streams register writes, then sweeps a commit strobe once the CRC is good.
module modbus_rtu_rsp_parser #(
  parameter int MAX_REGS = 16,
  parameter int T35_CLKS = 16700
) (
  input logic clk,
  input logic reset,
  modbus_rtu_rsp_parser_if.slave bus
);

  localparam int GW = $clog2(T35_CLKS + 1);
  localparam logic [GW-1:0] T35 = GW'(T35_CLKS);
  localparam logic [8:0] MAX_BYTES = 9'(2 * MAX_REGS);

  typedef enum logic [3:0] {
    S_ADDR, S_FUNC, S_COUNT, S_DATA_HI, S_DATA_LO,
    S_CRC_LO, S_CRC_HI, S_SWEEP, S_DISCARD
  } state_e;

  state_e state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;
  logic swrx_q, swrx_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] n_data_q, n_data_d;
  logic [15:0] data_in_q, data_in_d;
  logic data_strb_q, data_strb_d;
  logic cv_q, cv_d;
  logic frame_ok_q, frame_ok_d;
  logic frame_err_q, frame_err_d;
  logic [2:0] err_code_q, err_code_d;

  logic rxv;
  logic [7:0] rxd;
  logic gap_sat;
  logic in_frame;
  logic [15:0] crc_next;
  logic [7:0] idx_inc;

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign rxv      = bus.rx_valid;
  assign rxd      = bus.rx_data;
  assign gap_sat  = (gap_q == T35);
  assign crc_next = crc_upd(crc_q, rxd);
  assign idx_inc  = idx_q + 8'd1;
  assign in_frame = state_q inside {S_FUNC, S_COUNT, S_DATA_HI,
                                    S_DATA_LO, S_CRC_LO, S_CRC_HI};

  // Next-state, datapath and output pulse computation.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    gap_d       = rxv ? '0 : (gap_sat ? gap_q : gap_q + GW'(1));
    addr_d      = addr_q;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    swrx_d      = swrx_q;
    adr_d       = adr_q;
    n_data_d    = n_data_q;
    data_in_d   = data_in_q;
    err_code_d  = err_code_q;
    data_strb_d = 1'b0;
    cv_d        = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;

    if (in_frame && gap_sat && !rxv) begin
      frame_err_d = 1'b1;
      err_code_d  = 3'd2;
      state_d     = S_ADDR;
    end else begin
      unique case (state_q)
        S_ADDR: if (rxv) begin
          addr_d  = rxd;
          crc_d   = crc_upd(16'hFFFF, rxd);
          state_d = S_FUNC;
        end
        S_FUNC: if (rxv) begin
          crc_d = crc_next;
          unique case (1'b1)
            (rxd == 8'h03) || (rxd == 8'h04): state_d = S_COUNT;
            rxd[7]: begin
              frame_err_d = 1'b1;
              err_code_d  = 3'd3;
              state_d     = S_DISCARD;
            end
            default: begin
              frame_err_d = 1'b1;
              err_code_d  = 3'd4;
              state_d     = S_DISCARD;
            end
          endcase
        end
        S_COUNT: if (rxv) begin
          crc_d = crc_next;
          if (!rxd[0] && rxd != 8'd0 && {1'b0, rxd} <= MAX_BYTES) begin
            cnt_d   = {1'b0, rxd[7:1]};
            idx_d   = 8'd0;
            state_d = S_DATA_HI;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 3'd5;
            state_d     = S_DISCARD;
          end
        end
        S_DATA_HI: if (rxv) begin
          crc_d   = crc_next;
          byte_d  = rxd;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: if (rxv) begin
          crc_d       = crc_next;
          data_strb_d = 1'b1;
          data_in_d   = {byte_q, rxd};
          n_data_d    = idx_inc;
          adr_d       = addr_q;
          idx_d       = idx_inc;
          state_d     = (idx_inc == cnt_q) ? S_CRC_LO : S_DATA_HI;
        end
        S_CRC_LO: if (rxv) begin
          byte_d  = rxd;
          state_d = S_CRC_HI;
        end
        S_CRC_HI: if (rxv) begin
          if ({rxd, byte_q} == crc_q) begin
            cv_d     = 1'b1;
            n_data_d = 8'd1;
            adr_d    = addr_q;
            swrx_d   = 1'b0;
            state_d  = S_SWEEP;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 3'd1;
            state_d     = S_ADDR;
          end
        end
        S_SWEEP: begin
          if (rxv) swrx_d = 1'b1;
          if (n_data_q == cnt_q) begin
            frame_ok_d = 1'b1;
            state_d    = (swrx_q || rxv) ? S_DISCARD : S_ADDR;
          end else begin
            cv_d     = 1'b1;
            n_data_d = n_data_q + 8'd1;
          end
        end
        S_DISCARD: if (gap_sat && !rxv) state_d = S_ADDR;
        default: state_d = S_ADDR;
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_ADDR;
      crc_q       <= 16'hFFFF;
      gap_q       <= '0;
      addr_q      <= '0;
      byte_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      swrx_q      <= 1'b0;
      adr_q       <= '0;
      n_data_q    <= '0;
      data_in_q   <= '0;
      data_strb_q <= 1'b0;
      cv_q        <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      gap_q       <= gap_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      swrx_q      <= swrx_d;
      adr_q       <= adr_d;
      n_data_q    <= n_data_d;
      data_in_q   <= data_in_d;
      data_strb_q <= data_strb_d;
      cv_q        <= cv_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.adr          = adr_q;
  assign bus.n_data       = n_data_q;
  assign bus.data_in      = data_in_q;
  assign bus.data_strb    = data_strb_q;
  assign bus.crc_validate = cv_q;
  assign bus.frame_ok     = frame_ok_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.err_code     = err_code_q;

endmodule

// File: tb/tb_modbus_rtu_rsp_parser.sv
// Bench for the Modbus RTU response parser.
// Random and directed frames scored against a frame-level model.
module tb_modbus_rtu_rsp_parser;

  localparam int T35  = 64;
  localparam int MAXR = 16;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  modbus_rtu_rsp_parser_if bus();

  modbus_rtu_rsp_parser #(.MAX_REGS(MAXR), .T35_CLKS(T35)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] strb_q[$];
  logic [15:0] sweep_q[$];
  int ok_cnt = 0;
  int err_cnt = 0;
  int consec = 0;
  int cv_start = 0;
  int ok_cyc = 0;
  int ok_n = 0;
  logic prev_strb = 1'b0;
  logic prev_cv = 1'b0;

  always @(negedge clk) begin
    if (bus.data_strb) begin
      strb_q.push_back({bus.adr, bus.n_data, bus.data_in});
      if (prev_strb) consec++;
    end
    prev_strb = bus.data_strb;
    if (bus.crc_validate) begin
      if (!prev_cv) cv_start = cyc;
      sweep_q.push_back({bus.adr, bus.n_data});
    end
    prev_cv = bus.crc_validate;
    if (bus.frame_ok) begin
      ok_cnt++;
      ok_cyc = cyc;
      ok_n = int'(bus.n_data);
    end
    if (bus.frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input bq_t fr, input int len);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      c ^= {8'h00, fr[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0] exp_strb[$];
  int exp_sweep;
  int exp_ok;
  int exp_err;
  logic [2:0] exp_code = 3'd0;

  function automatic void model(input bq_t fr);
    int c, n, sz;
    logic [15:0] crc;
    exp_strb.delete();
    exp_sweep = 0;
    exp_ok = 0;
    exp_err = 0;
    sz = fr.size();
    if (sz < 2) begin exp_err = 1; exp_code = 3'd2; return; end
    if (!(fr[1] == 8'h03 || fr[1] == 8'h04)) begin
      exp_err = 1;
      exp_code = fr[1][7] ? 3'd3 : 3'd4;
      return;
    end
    if (sz < 3) begin exp_err = 1; exp_code = 3'd2; return; end
    c = int'(fr[2]);
    if (c == 0 || (c % 2) != 0 || c > 2 * MAXR) begin
      exp_err = 1; exp_code = 3'd5; return;
    end
    n = c / 2;
    for (int i = 0; i < n; i++)
      if (4 + 2 * i < sz)
        exp_strb.push_back({fr[0], 8'(i + 1), fr[3+2*i], fr[4+2*i]});
    if (sz < c + 5) begin exp_err = 1; exp_code = 3'd2; return; end
    crc = crc16(fr, c + 3);
    if ({fr[c+4], fr[c+3]} == crc) begin
      exp_sweep = n;
      exp_ok = 1;
    end else begin
      exp_err = 1;
      exp_code = 3'd1;
    end
  endfunction

  function automatic bq_t add_crc(input bq_t fr);
    logic [15:0] c;
    bq_t r;
    r = fr;
    c = crc16(fr, fr.size());
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    return r;
  endfunction

  function automatic bq_t mk_good(input logic [7:0] a, input logic [7:0] f,
                                  input int n);
    bq_t r;
    r.push_back(a);
    r.push_back(f);
    r.push_back(8'(2 * n));
    for (int i = 0; i < 2 * n; i++) r.push_back(8'($urandom_range(0, 255)));
    return add_crc(r);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic run_frame(input bq_t fr, input string tag);
    int s0, w0, o0, e0, ns, nw;
    s0 = strb_q.size();
    w0 = sweep_q.size();
    o0 = ok_cnt;
    e0 = err_cnt;
    model(fr);
    foreach (fr[i]) send_byte(fr[i]);
    repeat (T35 + 40) @(posedge clk);
    #1;
    ns = strb_q.size() - s0;
    nw = sweep_q.size() - w0;
    chk({tag, ".nstrb"}, ns, exp_strb.size());
    for (int i = 0; i < ns && i < exp_strb.size(); i++)
      chk({tag, ".strb"}, strb_q[s0+i], exp_strb[i]);
    chk({tag, ".nsweep"}, nw, exp_sweep);
    for (int i = 0; i < nw && i < exp_sweep; i++)
      chk({tag, ".sweep"}, sweep_q[w0+i], {fr[0], 8'(i + 1)});
    chk({tag, ".ok"}, ok_cnt - o0, exp_ok);
    chk({tag, ".err"}, err_cnt - e0, exp_err);
    chk({tag, ".code"}, bus.err_code, exp_code);
    chk({tag, ".consec"}, consec, 0);
    if (exp_ok != 0) begin
      chk({tag, ".cvlen"}, ok_cyc - cv_start, exp_sweep);
      chk({tag, ".okn"}, ok_n, exp_sweep);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".adr"}, bus.adr, 0);
    chk({tag, ".n"}, bus.n_data, 0);
    chk({tag, ".data"}, bus.data_in, 0);
    chk({tag, ".strb"}, bus.data_strb, 0);
    chk({tag, ".cv"}, bus.crc_validate, 0);
    chk({tag, ".ok"}, bus.frame_ok, 0);
    chk({tag, ".ferr"}, bus.frame_err, 0);
    chk({tag, ".code"}, bus.err_code, 0);
  endtask

  initial begin
    bq_t fr;
    int e0, mode, n, c;
    logic [7:0] f;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    fr = add_crc('{8'h01, 8'h03, 8'h04, 8'h00, 8'h0A, 8'h01, 8'h02});
    run_frame(fr, "good");

    fr[7] = fr[7] ^ 8'h01;
    run_frame(fr, "badcrc");

    fr = add_crc('{8'h02, 8'h83, 8'h02});
    run_frame(fr, "except");
    run_frame(mk_good(8'h02, 8'h04, 3), "after_exc");

    fr = add_crc('{8'h01, 8'h03, 8'h05, 8'h11, 8'h22, 8'h33});
    run_frame(fr, "cnt5");
    fr = add_crc('{8'h01, 8'h03, 8'h22, 8'h11, 8'h22});
    run_frame(fr, "cnt34");
    run_frame(mk_good(8'h01, 8'h03, 16), "cnt32");
    fr = add_crc('{8'h07, 8'h03, 8'h00});
    run_frame(fr, "cnt0");
    fr = add_crc('{8'h07, 8'h10, 8'h02, 8'h00, 8'h01});
    run_frame(fr, "badfunc");

    run_frame('{8'h01, 8'h03, 8'h04, 8'h00}, "trunc");

    e0 = err_cnt;
    fr = '{8'h01, 8'h03, 8'h04, 8'h00, 8'h0A, 8'h01};
    foreach (fr[i]) send_byte(fr[i]);
    #3;
    reset = 1'b0;
    #2;
    chk_zero("midrst");
    exp_code = 3'd0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (T35 + 10) @(posedge clk);
    chk("midrst.noerr", err_cnt - e0, 0);
    run_frame(mk_good(8'h01, 8'h03, 2), "post_rst");

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 7);
      n = $urandom_range(1, MAXR);
      fr = mk_good(8'($urandom_range(1, 247)),
                   ($urandom_range(0, 1) != 0) ? 8'h03 : 8'h04, n);
      if (mode == 4) begin
        c = $urandom_range(1, 2);
        fr[fr.size()-c] = fr[fr.size()-c] ^ 8'($urandom_range(1, 255));
      end else if (mode == 5) begin
        repeat ($urandom_range(1, fr.size() - 1)) void'(fr.pop_back());
      end else if (mode == 6) begin
        f = 8'($urandom_range(0, 255));
        if (f == 8'h03 || f == 8'h04) f = 8'h83;
        fr[1] = f;
      end else if (mode == 7) begin
        c = ($urandom_range(0, 1) != 0) ? 2 * $urandom_range(17, 127)
                                        : 2 * $urandom_range(0, 127) + 1;
        fr = add_crc('{fr[0], 8'h03, 8'(c), 8'h12, 8'h34});
      end
      run_frame(fr, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
